// File: rtl/input_conditioner_bank.sv
// Input conditioner bank: per-channel synchronizer, stability counter and
// registered debounced level with one-cycle rise/fall pulses.
module input_conditioner_bank #(
   parameter int CHANNELS      = 19,
   parameter int STABLE_CYCLES = 100000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [CHANNELS-1:0] raw_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] rise_pulse,
   output logic [CHANNELS-1:0] fall_pulse,
   output logic                any_change
);

   localparam int            CW   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

   // Stage 0 samples raw_in; the last stage is the synchronized view.
   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync;

   logic [CW-1:0]       count_q [CHANNELS];
   logic [CW-1:0]       count_d [CHANNELS];
   logic [CHANNELS-1:0] level_d;
   logic [CHANNELS-1:0] rise_d;
   logic [CHANNELS-1:0] fall_d;

   assign sync = sync_q[SYNC_STAGES-1];

   // Synchronizer chains run regardless of en so no stale level is held.
   always_ff @(posedge clk) begin
      // NOTE: the flop arrays are reset on purpose; a partial count or a stale
      // synchronizer value must not survive reset and cause a spurious edge.
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= raw_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // Per-channel next state: count while sync differs, commit on the last count.
   always_comb begin
      // NOTE: every output of this block is defaulted first so that no path
      // leaves a variable unassigned, which would infer a latch.
      level_d = level_out;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < CHANNELS; i++) count_d[i] = count_q[i];
      if (en) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (sync[i] == level_out[i]) begin
               count_d[i] = '0;
            end else if (count_q[i] == LAST) begin
               level_d[i] = sync[i];
               count_d[i] = '0;
               rise_d[i]  = sync[i];
               fall_d[i]  = ~sync[i];
            end else begin
               count_d[i] = count_q[i] + CW'(1);
            end
         end
      end
   end

   // Registered counters, levels and pulses; pulses clear on the next edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
         level_out  <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         any_change <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) count_q[i] <= count_d[i];
         level_out  <= level_d;
         rise_pulse <= rise_d;
         fall_pulse <= fall_d;
         any_change <= |{rise_d, fall_d};
      end
   end

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Self-checking bench for input_conditioner_bank (4 channels, 4 stable cycles,
// 2 sync stages): directed scenarios plus randomized traffic against a model.
module tb_input_conditioner_bank;

   localparam int CH     = 4;
   localparam int STABLE = 4;
   localparam int SYNC   = 2;

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [CH-1:0] raw_in;
   logic [CH-1:0] level_out;
   logic [CH-1:0] rise_pulse;
   logic [CH-1:0] fall_pulse;
   logic          any_change;

   int n_checks = 0;
   int n_fail   = 0;

   input_conditioner_bank #(
      .CHANNELS     (CH),
      .STABLE_CYCLES(STABLE),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .raw_in    (raw_in),
      .level_out (level_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .any_change(any_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raw samples travel through a delay queue; each channel
   // tracks how long its delayed value has disagreed with the output level.
   bit [CH-1:0] m_pipe [$];
   int          m_run [CH];
   bit [CH-1:0] m_level, m_rise, m_fall;
   bit          m_any;

   function automatic void model_reset();
      m_pipe = {};
      for (int s = 0; s < SYNC; s++) m_pipe.push_back('0);
      for (int i = 0; i < CH; i++) m_run[i] = 0;
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_any   = 1'b0;
   endfunction

   function automatic void model_edge();
      bit [CH-1:0] seen;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_pipe.push_front(raw_in);
      seen   = m_pipe.pop_back();
      m_rise = '0;
      m_fall = '0;
      if (en) begin
         for (int i = 0; i < CH; i++) begin
            if (seen[i] == m_level[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i]++;
               if (m_run[i] == STABLE) begin
                  m_level[i] = seen[i];
                  if (seen[i]) m_rise[i] = 1'b1;
                  else         m_fall[i] = 1'b1;
                  m_run[i] = 0;
               end
            end
         end
      end
      m_any = |{m_rise, m_fall};
   endfunction

   function automatic bit [3*CH:0] pack(bit [CH-1:0] l, bit [CH-1:0] r,
                                        bit [CH-1:0] f, bit a);
      return {l, r, f, a};
   endfunction

   // One rising edge, model updated on it, then outputs sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n  = 1'b0;
      en     = 1'b1;
      raw_in = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bit [3*CH:0] exp;
      rst_n  = 1'b0;
      en     = 1'b1;
      raw_in = 4'hF;
      for (int c = 0; c < 2; c++) begin
         step();
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold cyc%0d: got %h expected %h", c,
                     {level_out, rise_pulse, fall_pulse, any_change}, 13'h0);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         exp = pack((e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0, e == 6);
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== exp) begin
            n_fail++;
            $display("FAIL reset_release edge%0d: got %h expected %h", e,
                     {level_out, rise_pulse, fall_pulse, any_change}, exp);
         end
      end
   endtask

   task automatic test_glitch();
      apply_reset();
      raw_in = 4'b0001;
      for (int e = 1; e <= 11; e++) begin
         if (e == 4) raw_in = 4'b0000;
         step();
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== 13'h0) begin
            n_fail++;
            $display("FAIL glitch edge%0d: got %h expected %h", e,
                     {level_out, rise_pulse, fall_pulse, any_change}, 13'h0);
         end
      end
   endtask

   task automatic test_fall();
      bit [3*CH:0] exp;
      apply_reset();
      raw_in = 4'b0010;
      for (int e = 0; e < 8; e++) step();
      raw_in = 4'b0000;
      for (int e = 1; e <= 8; e++) begin
         step();
         exp = pack((e >= 6) ? 4'b0000 : 4'b0010, 4'h0,
                    (e == 6) ? 4'b0010 : 4'b0000, e == 6);
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== exp) begin
            n_fail++;
            $display("FAIL fall edge%0d: got %h expected %h", e,
                     {level_out, rise_pulse, fall_pulse, any_change}, exp);
         end
      end
   endtask

   task automatic test_enable();
      bit [3*CH:0] exp;
      apply_reset();
      raw_in = 4'b0100;
      for (int e = 0; e < 4; e++) step();
      en = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         step();
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== 13'h0) begin
            n_fail++;
            $display("FAIL enable_frozen cyc%0d: got %h expected %h", c,
                     {level_out, rise_pulse, fall_pulse, any_change}, 13'h0);
         end
      end
      en = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         step();
         exp = pack((e >= 2) ? 4'b0100 : 4'b0000, (e == 2) ? 4'b0100 : 4'b0000,
                    4'h0, e == 2);
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== exp) begin
            n_fail++;
            $display("FAIL enable_resume edge%0d: got %h expected %h", e,
                     {level_out, rise_pulse, fall_pulse, any_change}, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit [3*CH:0] exp;
      apply_reset();
      raw_in = 4'b1000;
      for (int e = 0; e < 4; e++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         step();
         exp = pack((e >= 6) ? 4'b1000 : 4'b0000, (e == 6) ? 4'b1000 : 4'b0000,
                    4'h0, e == 6);
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== exp) begin
            n_fail++;
            $display("FAIL reset_mid edge%0d: got %h expected %h", e,
                     {level_out, rise_pulse, fall_pulse, any_change}, exp);
         end
      end
   endtask

   task automatic test_simultaneous();
      bit [3*CH:0] exp;
      int          n_any;
      apply_reset();
      step();
      raw_in = 4'b1001;
      n_any  = 0;
      for (int e = 1; e <= 9; e++) begin
         step();
         if (any_change === 1'b1) n_any++;
         exp = pack((e >= 6) ? 4'b1001 : 4'b0000, (e == 6) ? 4'b1001 : 4'b0000,
                    4'h0, e == 6);
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !== exp) begin
            n_fail++;
            $display("FAIL simultaneous edge%0d: got %h expected %h", e,
                     {level_out, rise_pulse, fall_pulse, any_change}, exp);
         end
      end
      n_checks++;
      if (n_any != 1) begin
         n_fail++;
         $display("FAIL simultaneous_any_count: got %0d expected 1", n_any);
      end
   endtask

   task automatic test_random();
      int hold;
      apply_reset();
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         if (hold == 0) begin
            raw_in = raw_in ^ CH'($urandom_range(0, 15));
            hold   = $urandom_range(1, 8);
         end
         hold--;
         en    = ($urandom_range(0, 9) != 0);
         rst_n = ($urandom_range(0, 199) != 0);
         step();
         n_checks++;
         if ({level_out, rise_pulse, fall_pulse, any_change} !==
             pack(m_level, m_rise, m_fall, m_any)) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %h expected %h", c,
                     {level_out, rise_pulse, fall_pulse, any_change},
                     pack(m_level, m_rise, m_fall, m_any));
         end
      end
      rst_n = 1'b1;
      en    = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 1'b1;
      raw_in = '0;
      model_reset();
      test_reset();
      test_glitch();
      test_fall();
      test_enable();
      test_reset_mid();
      test_simultaneous();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/input_conditioner_bank.md
INPUT_CONDITIONER_BANK -- requirements
Module: input_conditioner_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 19, number of independent raw inputs (buttons plus switches), range 1..64.
REQ-002 SHALL have parameter STABLE_CYCLES, default 100000, consecutive clk edges a synchronized input must differ from its output before the output follows, range >= 1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth per channel, range 2..4.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1, conditioning enable; low freezes all counters and outputs.
REQ-007 SHALL have port raw_in, input, CHANNELS, asynchronous raw button/switch levels.
REQ-008 SHALL have port level_out, output, CHANNELS, debounced registered levels.
REQ-009 SHALL have port rise_pulse, output, CHANNELS, one-cycle pulse on the edge level_out[i] goes 0->1.
REQ-010 SHALL have port fall_pulse, output, CHANNELS, one-cycle pulse on the edge level_out[i] goes 1->0.
REQ-011 SHALL have port any_change, output, 1, registered OR of rise_pulse and fall_pulse, same cycle.

Function
REQ-012 SHALL pass each raw_in[i] through its own SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-013 SHALL keep one counter per channel, width clog2(STABLE_CYCLES+1), never wrapping.
REQ-014 SHALL, on each edge with en=1 and sync[i]==level_out[i], clear counter[i] to 0.
REQ-015 SHALL, on each edge with en=1 and sync[i]!=level_out[i] and counter[i] < STABLE_CYCLES-1, increment counter[i] by 1.
REQ-016 SHALL, on each edge with en=1 and sync[i]!=level_out[i] and counter[i]==STABLE_CYCLES-1, load level_out[i]<=sync[i], clear counter[i], and assert the matching rise_pulse[i] or fall_pulse[i] for exactly that cycle.
REQ-017 SHALL give latency of exactly SYNC_STAGES+STABLE_CYCLES rising edges from the first edge sampling a new stable raw_in[i] to the edge updating level_out[i].
REQ-018 SHALL NOT change level_out[i] for a raw_in[i] disturbance whose synchronized duration is shorter than STABLE_CYCLES edges; any return to equality restarts the count from 0.
REQ-019 SHALL, with STABLE_CYCLES=1, update level_out[i] on the first edge where sync[i] differs.
REQ-020 SHALL process channels fully independently; simultaneous qualifying changes on several channels SHALL all update on the same edge.
REQ-021 SHALL, while en=0, hold counters and level_out, drive rise_pulse, fall_pulse and any_change to 0, and keep synchronizer chains running.
REQ-022 SHALL deassert every pulse output one cycle after assertion; no pulse lasts more than one cycle.

Reset
REQ-023 SHALL, on an edge with rst_n=0, clear all synchronizer flops, counters, level_out, rise_pulse, fall_pulse and any_change to 0, regardless of en.
REQ-024 SHALL, on rst_n asserted mid-count, discard the partial count; after release a held-high raw input needs the full SYNC_STAGES+STABLE_CYCLES edges again.
REQ-025 SHALL, on the first edge with rst_n=1, resume normal operation with no spurious pulse.

Verification (CHANNELS=4, STABLE_CYCLES=4, SYNC_STAGES=2, en=1 unless stated)
REQ-026 SHALL cover: rst_n=0 2 cycles, raw_in=4'hF -> all outputs 0 during reset; raw_in held -> level_out=4'hF at edge 6 after release, rise_pulse=4'hF and any_change=1 for that one cycle only.
REQ-027 SHALL cover: raw_in[0] high for 3 edges then low -> level_out[0] stays 0, no pulses.
REQ-028 SHALL cover: raw_in[1] 1->0 after settling -> fall_pulse=4'b0010 exactly 6 edges later, one cycle wide.
REQ-029 SHALL cover: raw_in[2] high, en dropped 0 after 4 edges for 10 cycles, then 1 -> no change while en=0; level_out[2] rises 2 edges after en returns.
REQ-030 SHALL cover: raw_in[3] high, rst_n pulsed low at edge 5 -> level_out[3] rises at edge 6 after rst_n release, not earlier.
REQ-031 SHALL cover: raw_in[0] and raw_in[3] switched together -> both update and pulse on the same edge, any_change=1 once.
